kronos_mem_responder: RTL and testbench
=======================================

Name: kronos_mem_responder

Overview:
- Synthesizable memory-side responder for the kronos_core instruction and data request/grant buses.
- Arbitrates both buses onto one single-port 32-bit SRAM (spsram32-style: en, wr_en, wr_mask, 1-cycle read latency) and generates the grants.
- Data has priority, with a starvation guard for instruction fetch and programmable wait states.
- Replaces ad-hoc bench glue in FPGA/SoC top levels and in the compliance bench.

Parameters:
- MEMSIZE, 11, log2 of memory depth in 32-bit words; word index = addr[2+:MEMSIZE].
- WAIT_CYCLES, 0, extra idle cycles inserted between acceptance and the SRAM access (0..15).
- STARVE_LIMIT, 4, consecutive data grants allowed while instr_req is pending before instruction wins one arbitration (1..15).
- TOHOST, 32'h0000_1000, byte address watched by the optional host-exit feature.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- instr_addr  in  32  fetch byte address.
- instr_req  in  1  fetch request, held until instr_gnt.
- instr_data  out  32  fetch data, valid in the instr_gnt cycle.
- instr_gnt  out  1  single-cycle fetch grant.
- data_addr  in  32  load/store byte address.
- data_wr_data  in  32  store data.
- data_wr_mask  in  4  store byte enables.
- data_rd_req  in  1  load request, held until data_gnt.
- data_wr_req  in  1  store request, held until data_gnt.
- data_rd_data  out  32  load data, valid in the data_gnt cycle.
- data_gnt  out  1  single-cycle load/store grant.
- mem_addr  out  MEMSIZE  SRAM word address.
- mem_wdata  out  32  SRAM write data.
- mem_wmask  out  4  SRAM byte mask.
- mem_en  out  1  SRAM access strobe.
- mem_wren  out  1  SRAM write strobe.
- mem_rdata  in  32  SRAM read data, one cycle after mem_en.

Behaviour:
- Reset values:
  - Outputs instr_gnt, data_gnt, mem_en, mem_wren = 0; mem_addr, mem_wdata, mem_wmask = 0.
  - State = IDLE; starvation counter = 0; wait counter = 0.
- States: IDLE, WAIT, ACCESS, RESP.
- IDLE, arbitration:
  - Pick data if data_rd_req|data_wr_req, unless the starvation counter == STARVE_LIMIT and instr_req=1, in which case pick instr.
  - Otherwise pick instr if instr_req.
  - Latch the winner's address, wdata, mask and direction.
  - Next state: WAIT if WAIT_CYCLES>0, else ACCESS in the same cycle (combinational mem_en, so zero-wait latency matches the raw bench: gnt exactly one cycle after req).
- WAIT: count WAIT_CYCLES cycles, then go to ACCESS.
- ACCESS:
  - Drive mem_en=1; mem_wren=1 for stores; drive mem_addr, mem_wdata, mem_wmask.
  - Next state RESP.
- RESP:
  - Pulse the winner's gnt for one cycle.
  - instr_data and data_rd_data are both driven from mem_rdata.
  - No new request is accepted this cycle; return to IDLE. Minimum two cycles per transaction at WAIT_CYCLES=0.
- Starvation counter:
  - Increments on each data grant while instr_req=1.
  - Clears on an instr grant or when instr_req=0.
  - Saturates at STARVE_LIMIT.
- Request conventions:
  - A request seen with its gnt in the same cycle is already served; the core drops it.
  - data_rd_req and data_wr_req both high: treat as a write.
  - Addresses above the memory size alias: upper bits are ignored. addr[1:0] is ignored.
- Asynchronous rst mid-transaction: abort immediately, no gnt issued, any pending SRAM write is dropped, return to IDLE.

Optional Feature:
- Macro: KRONOS_MEM_TOHOST_EN.
- When defined, adds outputs host_done (1) and host_code (32).
- On a store accepted in ACCESS with mem_addr == TOHOST[2+:MEMSIZE]:
  - Latch host_code = data_wr_data.
  - Set host_done=1 (sticky until rst) if data_wr_data[0]=1.
  - The store still writes memory.
- When not defined, the ports do not exist and no compare logic is built.

Test Plan:
- WAIT_CYCLES=0, instr_req at 0x10, mem[4]=0xDEADBEEF -> mem_en with mem_addr=4 the same cycle; instr_gnt=1 next cycle with instr_data=0xDEADBEEF.
- instr_req and data_rd_req at 0x20 (mem[8]=0x12345678) raised together -> data_gnt first with data_rd_data=0x12345678; instr_gnt two cycles later.
- Store 0xAABBCCDD, mask 4'b0101, to 0x40 over 0x11111111 -> data_gnt after one cycle; a readback returns 0x11BB11DD.
- STARVE_LIMIT=2, continuous data requests plus instr_req -> grant order data, data, instr, data, data, instr.
- WAIT_CYCLES=3 -> gnt exactly 5 cycles after req.
- Assert rst during WAIT -> no gnt, mem_en stays 0; a fresh request afterwards is served normally.
- With KRONOS_MEM_TOHOST_EN, store 1 to TOHOST -> host_done=1, host_code=1.

Source files
------------

// File: rtl/kronos_mem_responder.sv
// Arbitrates the kronos_core instruction and data buses onto one single-port SRAM
// (1-cycle read latency). Data wins arbitration, but instruction fetch wins one slot
// after STARVE_LIMIT consecutive data grants. WAIT_CYCLES adds wait states before
// each access. Optional host-exit monitor: define KRONOS_MEM_TOHOST_EN.
module kronos_mem_responder #(
    parameter int          MEMSIZE      = 11,
    parameter int          WAIT_CYCLES  = 0,
    parameter int          STARVE_LIMIT = 4,
    parameter logic [31:0] TOHOST       = 32'h0000_1000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        instr_addr,
    input  logic               instr_req,
    output logic [31:0]        instr_data,
    output logic               instr_gnt,
    input  logic [31:0]        data_addr,
    input  logic [31:0]        data_wr_data,
    input  logic [3:0]         data_wr_mask,
    input  logic               data_rd_req,
    input  logic               data_wr_req,
    output logic [31:0]        data_rd_data,
    output logic               data_gnt,
    output logic [MEMSIZE-1:0] mem_addr,
    output logic [31:0]        mem_wdata,
    output logic [3:0]         mem_wmask,
    output logic               mem_en,
    output logic               mem_wren,
    input  logic [31:0]        mem_rdata
`ifdef KRONOS_MEM_TOHOST_EN
    ,
    output logic               host_done,
    output logic [31:0]        host_code
`endif
);

    typedef enum logic [1:0] {IDLE, WAIT, ACCESS, RESP} state_t;

    localparam bit         ZERO_WAIT  = (WAIT_CYCLES == 0);
    localparam logic [3:0] WAIT_LAST  = ZERO_WAIT ? 4'd0 : 4'(WAIT_CYCLES - 1);
    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    state_t             state_reg;
    logic [3:0]         wait_cnt_reg;
    logic [3:0]         starve_cnt_reg;
    logic [MEMSIZE-1:0] addr_reg;
    logic [31:0]        wdata_reg;
    logic [3:0]         wmask_reg;
    logic               wr_reg;
    logic               sel_instr_reg;
    logic               instr_gnt_reg;
    logic               data_gnt_reg;

    // Arbitration decision, only meaningful while IDLE
    logic               data_pending;
    logic               pick_instr;
    logic               pick_data;
    logic               accept;
    logic [MEMSIZE-1:0] win_addr;
    logic               win_wr;
    logic [3:0]         win_wmask;

    assign data_pending = data_rd_req | data_wr_req;
    assign pick_instr   = instr_req & (~data_pending | (starve_cnt_reg == STARVE_MAX));
    assign pick_data    = data_pending & ~pick_instr;
    assign accept       = (state_reg == IDLE) & (pick_instr | pick_data);
    assign win_addr     = pick_instr ? instr_addr[2+:MEMSIZE] : data_addr[2+:MEMSIZE];
    assign win_wr       = pick_data & data_wr_req;
    assign win_wmask    = win_wr ? data_wr_mask : 4'b0000;

    // Byte address bits outside the word index alias and are deliberately ignored
    logic unused_addr_bits;
    assign unused_addr_bits = ^{instr_addr, data_addr};

    // SRAM port: with no wait states the access is issued straight from IDLE so the
    // grant lands one cycle after the request; rst kills any in-flight access.
    always_comb begin
        mem_en    = 1'b0;
        mem_wren  = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wmask = '0;
        if (!rst) begin
            if (state_reg == ACCESS) begin
                mem_en    = 1'b1;
                mem_wren  = wr_reg;
                mem_addr  = addr_reg;
                mem_wdata = wdata_reg;
                mem_wmask = wmask_reg;
            end else if (ZERO_WAIT && accept) begin
                mem_en    = 1'b1;
                mem_wren  = win_wr;
                mem_addr  = win_addr;
                mem_wdata = data_wr_data;
                mem_wmask = win_wmask;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            wait_cnt_reg   <= '0;
            starve_cnt_reg <= '0;
            addr_reg       <= '0;
            wdata_reg      <= '0;
            wmask_reg      <= '0;
            wr_reg         <= 1'b0;
            sel_instr_reg  <= 1'b0;
            instr_gnt_reg  <= 1'b0;
            data_gnt_reg   <= 1'b0;
        end else begin
            instr_gnt_reg <= 1'b0;
            data_gnt_reg  <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        addr_reg      <= win_addr;
                        wdata_reg     <= data_wr_data;
                        wmask_reg     <= win_wmask;
                        wr_reg        <= win_wr;
                        sel_instr_reg <= pick_instr;
                        wait_cnt_reg  <= '0;
                        if (ZERO_WAIT) begin
                            state_reg     <= RESP;
                            instr_gnt_reg <= pick_instr;
                            data_gnt_reg  <= pick_data;
                        end else begin
                            state_reg <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (wait_cnt_reg == WAIT_LAST) begin
                        state_reg <= ACCESS;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + 4'd1;
                    end
                end
                ACCESS: begin
                    state_reg     <= RESP;
                    instr_gnt_reg <= sel_instr_reg;
                    data_gnt_reg  <= ~sel_instr_reg;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase

            // Starvation guard counts data grants taken while a fetch is waiting
            if (instr_gnt_reg || !instr_req) begin
                starve_cnt_reg <= '0;
            end else if (data_gnt_reg && (starve_cnt_reg != STARVE_MAX)) begin
                starve_cnt_reg <= starve_cnt_reg + 4'd1;
            end
        end
    end

    assign instr_gnt    = instr_gnt_reg;
    assign data_gnt     = data_gnt_reg;
    assign instr_data   = mem_rdata;
    assign data_rd_data = mem_rdata;

`ifdef KRONOS_MEM_TOHOST_EN
    localparam logic [MEMSIZE-1:0] TOHOST_IDX = TOHOST[2+:MEMSIZE];

    logic        host_done_reg;
    logic [31:0] host_code_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            host_done_reg <= 1'b0;
            host_code_reg <= '0;
        end else if (mem_en && mem_wren && (mem_addr == TOHOST_IDX)) begin
            host_code_reg <= mem_wdata;
            if (mem_wdata[0]) begin
                host_done_reg <= 1'b1;
            end
        end
    end

    assign host_done = host_done_reg;
    assign host_code = host_code_reg;
`else
    logic unused_tohost;
    assign unused_tohost = ^TOHOST;
`endif

endmodule

// File: tb/tb_kronos_mem_responder.sv
// Bench for kronos_mem_responder: a zero-wait instance (STARVE_LIMIT=2) and a
// three-wait-state instance, each on its own SRAM model, checked against a reference.
module tb_kronos_mem_responder;

    localparam int MS = 11;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [31:0] instr_addr, data_addr, data_wr_data;
    logic [3:0]  data_wr_mask;
    logic        instr_req, data_rd_req, data_wr_req;
    logic        sel_w;

    logic [31:0] instr_data_0, data_rd_data_0, mem_wdata_0, mem_rdata_0;
    logic [31:0] instr_data_1, data_rd_data_1, mem_wdata_1, mem_rdata_1;
    logic [MS-1:0] mem_addr_0, mem_addr_1;
    logic [3:0]  mem_wmask_0, mem_wmask_1;
    logic        instr_gnt_0, data_gnt_0, mem_en_0, mem_wren_0;
    logic        instr_gnt_1, data_gnt_1, mem_en_1, mem_wren_1;
`ifdef KRONOS_MEM_TOHOST_EN
    logic        host_done_0, host_done_1;
    logic [31:0] host_code_0, host_code_1;
`endif

    logic ireq_0, rreq_0, wreq_0, ireq_1, rreq_1, wreq_1;
    assign ireq_0 = instr_req & ~sel_w;
    assign rreq_0 = data_rd_req & ~sel_w;
    assign wreq_0 = data_wr_req & ~sel_w;
    assign ireq_1 = instr_req & sel_w;
    assign rreq_1 = data_rd_req & sel_w;
    assign wreq_1 = data_wr_req & sel_w;

    kronos_mem_responder #(.MEMSIZE(MS), .WAIT_CYCLES(0), .STARVE_LIMIT(2)) dut (
        .clk(clk), .rst(rst),
        .instr_addr(instr_addr), .instr_req(ireq_0), .instr_data(instr_data_0), .instr_gnt(instr_gnt_0),
        .data_addr(data_addr), .data_wr_data(data_wr_data), .data_wr_mask(data_wr_mask),
        .data_rd_req(rreq_0), .data_wr_req(wreq_0), .data_rd_data(data_rd_data_0), .data_gnt(data_gnt_0),
        .mem_addr(mem_addr_0), .mem_wdata(mem_wdata_0), .mem_wmask(mem_wmask_0),
        .mem_en(mem_en_0), .mem_wren(mem_wren_0), .mem_rdata(mem_rdata_0)
`ifdef KRONOS_MEM_TOHOST_EN
        , .host_done(host_done_0), .host_code(host_code_0)
`endif
    );

    kronos_mem_responder #(.MEMSIZE(MS), .WAIT_CYCLES(3), .STARVE_LIMIT(4)) dut_w (
        .clk(clk), .rst(rst),
        .instr_addr(instr_addr), .instr_req(ireq_1), .instr_data(instr_data_1), .instr_gnt(instr_gnt_1),
        .data_addr(data_addr), .data_wr_data(data_wr_data), .data_wr_mask(data_wr_mask),
        .data_rd_req(rreq_1), .data_wr_req(wreq_1), .data_rd_data(data_rd_data_1), .data_gnt(data_gnt_1),
        .mem_addr(mem_addr_1), .mem_wdata(mem_wdata_1), .mem_wmask(mem_wmask_1),
        .mem_en(mem_en_1), .mem_wren(mem_wren_1), .mem_rdata(mem_rdata_1)
`ifdef KRONOS_MEM_TOHOST_EN
        , .host_done(host_done_1), .host_code(host_code_1)
`endif
    );

    // Single-port SRAM models with registered read
    logic [31:0] sram0 [0:(1<<MS)-1];
    logic [31:0] sram1 [0:(1<<MS)-1];
    always @(posedge clk) begin
        if (mem_en_0) begin
            if (mem_wren_0)
                for (int b = 0; b < 4; b++)
                    if (mem_wmask_0[b]) sram0[mem_addr_0][8*b+:8] <= mem_wdata_0[8*b+:8];
            mem_rdata_0 <= sram0[mem_addr_0];
        end
        if (mem_en_1) begin
            if (mem_wren_1)
                for (int b = 0; b < 4; b++)
                    if (mem_wmask_1[b]) sram1[mem_addr_1][8*b+:8] <= mem_wdata_1[8*b+:8];
            mem_rdata_1 <= sram1[mem_addr_1];
        end
    end

    // Views of whichever instance is selected
    logic        igt, dgt, men, mwren;
    logic [31:0] idata, ddata, mwdata;
    logic [MS-1:0] maddr;
    logic [3:0]  mwmask;
    assign igt    = sel_w ? instr_gnt_1    : instr_gnt_0;
    assign dgt    = sel_w ? data_gnt_1     : data_gnt_0;
    assign idata  = sel_w ? instr_data_1   : instr_data_0;
    assign ddata  = sel_w ? data_rd_data_1 : data_rd_data_0;
    assign men    = sel_w ? mem_en_1       : mem_en_0;
    assign mwren  = sel_w ? mem_wren_1     : mem_wren_0;
    assign maddr  = sel_w ? mem_addr_1     : mem_addr_0;
    assign mwdata = sel_w ? mem_wdata_1    : mem_wdata_0;
    assign mwmask = sel_w ? mem_wmask_1    : mem_wmask_0;

    int total = 0;
    int bad = 0;
    logic [31:0] rnd_ref [16];

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] m);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) r[8*b+:8] = m[b] ? nw[8*b+:8] : old[8*b+:8];
        return r;
    endfunction

    // Raise one request at a negedge and wait (bounded) for its grant; lat=-1 on timeout
    task automatic xact(input bit is_instr, input bit rd, input bit wr, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [3:0] m,
                        output logic [31:0] rdata, output int lat);
        bit got;
        got = 1'b0;
        rdata = 'x;
        lat = 0;
        if (is_instr) begin
            instr_addr = addr;
            instr_req = 1'b1;
        end else begin
            data_addr = addr;
            data_wr_data = wd;
            data_wr_mask = m;
            data_rd_req = rd;
            data_wr_req = wr;
        end
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk);
            lat++;
            if (is_instr ? igt : dgt) begin
                got = 1'b1;
                rdata = is_instr ? idata : ddata;
            end
        end
        if (!got) lat = -1;
        instr_req = 1'b0;
        data_rd_req = 1'b0;
        data_wr_req = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) begin
            sel_w = k[0];
            #1;
            total++;
            if (igt !== 1'b0 || dgt !== 1'b0 || men !== 1'b0 || mwren !== 1'b0 ||
                maddr !== '0 || mwdata !== '0 || mwmask !== '0) begin
                bad++;
                $display("FAIL reset_outputs inst=%0d got gnt=%b%b en=%b wren=%b addr=%h wd=%h wm=%h need all zero",
                         k, igt, dgt, men, mwren, maddr, mwdata, mwmask);
            end
        end
`ifdef KRONOS_MEM_TOHOST_EN
        total++;
        if (host_done_0 !== 1'b0 || host_code_0 !== 32'h0) begin
            bad++;
            $display("FAIL reset_host got done=%b code=%h need 0/0", host_done_0, host_code_0);
        end
`endif
        repeat (2) @(negedge clk);
        rst = 1'b0;
        sel_w = 1'b0;
        @(negedge clk);
        total++;
        if (mem_en_0 !== 1'b0 || mem_en_1 !== 1'b0) begin
            bad++;
            $display("FAIL idle_en got %b%b need 00", mem_en_0, mem_en_1);
        end
        $display("reset: outputs checked");
    endtask

    task automatic test_fetch();
        logic [31:0] rd;
        int lat;
        sel_w = 1'b0;
        xact(0, 0, 1, 32'h10, 32'hDEADBEEF, 4'hF, rd, lat);
        total++;
        if (lat !== 1) begin bad++; $display("FAIL store_lat got %0d need 1", lat); end
        @(negedge clk);
        instr_addr = 32'h10;
        instr_req = 1'b1;
        #1;
        total++;
        if (mem_en_0 !== 1'b1 || mem_addr_0 !== 11'd4 || mem_wren_0 !== 1'b0) begin
            bad++;
            $display("FAIL fetch_mem_en got en=%b addr=%h wren=%b need 1/004/0", mem_en_0, mem_addr_0, mem_wren_0);
        end
        @(negedge clk);
        total++;
        if (instr_gnt_0 !== 1'b1 || instr_data_0 !== 32'hDEADBEEF) begin
            bad++;
            $display("FAIL fetch_gnt got gnt=%b data=%h need 1/deadbeef", instr_gnt_0, instr_data_0);
        end
        instr_req = 1'b0;
        @(negedge clk);
        total++;
        if (instr_gnt_0 !== 1'b0) begin bad++; $display("FAIL gnt_pulse got %b need 0", instr_gnt_0); end
        $display("fetch: addr=0x10 data=%h", instr_data_0);
    endtask

    task automatic test_priority();
        logic [31:0] rd, dval, ival;
        int lat, t, td, ti;
        xact(0, 0, 1, 32'h20, 32'h12345678, 4'hF, rd, lat);
        @(negedge clk);
        instr_addr = 32'h10;
        instr_req = 1'b1;
        data_addr = 32'h20;
        data_rd_req = 1'b1;
        td = -1; ti = -1; t = 0; dval = 'x; ival = 'x;
        while ((td < 0 || ti < 0) && t < 20) begin
            @(negedge clk);
            t++;
            if (data_gnt_0) begin td = t; dval = data_rd_data_0; data_rd_req = 1'b0; end
            if (instr_gnt_0) begin ti = t; ival = instr_data_0; instr_req = 1'b0; end
        end
        instr_req = 1'b0;
        data_rd_req = 1'b0;
        total++;
        if (td !== 1 || dval !== 32'h12345678) begin
            bad++;
            $display("FAIL prio_data got t=%0d data=%h need 1/12345678", td, dval);
        end
        total++;
        if (ti !== 3 || ival !== 32'hDEADBEEF) begin
            bad++;
            $display("FAIL prio_instr got t=%0d data=%h need 3/deadbeef", ti, ival);
        end
        $display("priority: data at %0d, instr at %0d", td, ti);
        @(negedge clk);
    endtask

    task automatic test_mask_store();
        logic [31:0] rd;
        int lat;
        xact(0, 0, 1, 32'h40, 32'h11111111, 4'hF, rd, lat);
        @(negedge clk);
        xact(0, 0, 1, 32'h40, 32'hAABBCCDD, 4'b0101, rd, lat);
        total++;
        if (lat !== 1) begin bad++; $display("FAIL mask_store_lat got %0d need 1", lat); end
        @(negedge clk);
        xact(0, 1, 0, 32'h40, 32'h0, 4'h0, rd, lat);
        total++;
        if (rd !== 32'h11BB11DD || lat !== 1) begin
            bad++;
            $display("FAIL mask_readback got %h lat=%0d need 11bb11dd lat=1", rd, lat);
        end
        @(negedge clk);
        // Aliased address: upper bits and addr[1:0] must not matter
        xact(0, 1, 0, 32'h8000_0043, 32'h0, 4'h0, rd, lat);
        total++;
        if (rd !== 32'h11BB11DD) begin bad++; $display("FAIL alias_read got %h need 11bb11dd", rd); end
        @(negedge clk);
        // rd+wr together is a store
        xact(0, 1, 1, 32'h44, 32'hCAFEF00D, 4'hF, rd, lat);
        @(negedge clk);
        xact(0, 1, 0, 32'h44, 32'h0, 4'h0, rd, lat);
        total++;
        if (rd !== 32'hCAFEF00D) begin bad++; $display("FAIL rdwr_is_write got %h need cafef00d", rd); end
        $display("mask_store: readback %h", rd);
        @(negedge clk);
    endtask

    task automatic test_starve();
        bit order [$];
        int t;
        instr_addr = 32'h10;
        data_addr = 32'h40;
        instr_req = 1'b1;
        data_rd_req = 1'b1;
        t = 0;
        while (order.size() < 6 && t < 40) begin
            @(negedge clk);
            t++;
            if (instr_gnt_0) order.push_back(1'b1);
            if (data_gnt_0) order.push_back(1'b0);
        end
        instr_req = 1'b0;
        data_rd_req = 1'b0;
        total++;
        if (order.size() != 6) begin
            bad++;
            $display("FAIL starve_count got %0d grants need 6", order.size());
        end
        for (int i = 0; i < order.size(); i++) begin
            total++;
            if (order[i] !== ((i % 3) == 2)) begin
                bad++;
                $display("FAIL starve_order idx=%0d got instr=%b need instr=%b", i, order[i], (i % 3) == 2);
            end
        end
        $display("starve: %0d grants in %0d cycles", order.size(), t);
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd;
        int lat;
        xact(0, 1, 0, 32'h44, 32'h0, 4'h0, rd, lat);
        xact(0, 1, 0, 32'h40, 32'h0, 4'h0, rd, lat);
        total++;
        if (lat !== 2 || rd !== 32'h11BB11DD) begin
            bad++;
            $display("FAIL back_to_back got lat=%0d data=%h need 2/11bb11dd", lat, rd);
        end
        $display("back_to_back: second lat=%0d", lat);
        @(negedge clk);
    endtask

    task automatic test_wait();
        logic [31:0] rd;
        int lat;
        sel_w = 1'b1;
        xact(0, 0, 1, 32'h40, 32'h5A5A1234, 4'hF, rd, lat);
        total++;
        if (lat !== 5) begin bad++; $display("FAIL wait_store_lat got %0d need 5", lat); end
        @(negedge clk);
        xact(1, 0, 0, 32'h40, 32'h0, 4'h0, rd, lat);
        total++;
        if (lat !== 5 || rd !== 32'h5A5A1234) begin
            bad++;
            $display("FAIL wait_fetch got lat=%0d data=%h need 5/5a5a1234", lat, rd);
        end
        $display("wait: lat=%0d data=%h", lat, rd);
        @(negedge clk);
    endtask

    task automatic test_reset_wait();
        logic [31:0] rd;
        int lat, seen;
        sel_w = 1'b1;
        data_addr = 32'h40;
        data_wr_data = 32'hFFFF0000;
        data_wr_mask = 4'hF;
        data_wr_req = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        data_wr_req = 1'b0;
        seen = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            if (data_gnt_1 || mem_en_1) seen++;
            @(negedge clk);
        end
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            #1;
            if (data_gnt_1 || mem_en_1) seen++;
            @(negedge clk);
        end
        total++;
        if (seen !== 0) begin bad++; $display("FAIL rst_abort got %0d gnt/en cycles need 0", seen); end
        xact(0, 1, 0, 32'h40, 32'h0, 4'h0, rd, lat);
        total++;
        if (lat !== 5 || rd !== 32'h5A5A1234) begin
            bad++;
            $display("FAIL rst_recover got lat=%0d data=%h need 5/5a5a1234", lat, rd);
        end
        $display("reset_wait: recovered lat=%0d data=%h", lat, rd);
        sel_w = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [31:0] rd, addr, wd, expv;
        logic [3:0] m;
        int lat, w, op;
        sel_w = 1'b0;
        for (int i = 0; i < 56; i++) begin
            w = (i < 16) ? i : int'($urandom_range(0, 15));
            op = (i < 16) ? 0 : int'($urandom_range(0, 2));
            addr = ($urandom & 32'hFFFF_E000) | ((32'(w) + 32'd64) << 2) | ($urandom & 32'h3);
            wd = $urandom;
            m = (i < 16) ? 4'hF : 4'($urandom);
            if (op == 0) begin
                xact(0, $urandom_range(0, 1) == 1, 1, addr, wd, m, rd, lat);
                rnd_ref[w] = merge(rnd_ref[w], wd, m);
                expv = 'x;
            end else begin
                xact(op == 2, op == 1, 0, addr, 32'h0, 4'h0, rd, lat);
                expv = rnd_ref[w];
            end
            total++;
            if (lat !== 1 || (op != 0 && rd !== expv)) begin
                bad++;
                $display("FAIL random op=%0d addr=%h got lat=%0d data=%h need lat=1 data=%h", op, addr, lat, rd, expv);
            end else begin
                $display("random: op=%0d addr=%h data=%h", op, addr, (op == 0) ? wd : rd);
            end
            @(negedge clk);
        end
    endtask

`ifdef KRONOS_MEM_TOHOST_EN
    task automatic test_tohost();
        logic [31:0] rd;
        int lat;
        sel_w = 1'b0;
        xact(0, 0, 1, 32'h1000, 32'h2, 4'hF, rd, lat);
        @(negedge clk);
        total++;
        if (host_done_0 !== 1'b0 || host_code_0 !== 32'h2) begin
            bad++;
            $display("FAIL tohost_even got done=%b code=%h need 0/2", host_done_0, host_code_0);
        end
        xact(0, 0, 1, 32'h1000, 32'h1, 4'hF, rd, lat);
        @(negedge clk);
        total++;
        if (host_done_0 !== 1'b1 || host_code_0 !== 32'h1) begin
            bad++;
            $display("FAIL tohost_done got done=%b code=%h need 1/1", host_done_0, host_code_0);
        end
        xact(0, 1, 0, 32'h1000, 32'h0, 4'h0, rd, lat);
        total++;
        if (rd !== 32'h1) begin bad++; $display("FAIL tohost_mem got %h need 1", rd); end
        $display("tohost: done=%b code=%h", host_done_0, host_code_0);
        @(negedge clk);
    endtask
`endif

    initial begin
        sel_w = 1'b0;
        instr_req = 1'b0;
        data_rd_req = 1'b0;
        data_wr_req = 1'b0;
        instr_addr = '0;
        data_addr = '0;
        data_wr_data = '0;
        data_wr_mask = '0;
        rst = 1'b0;
        @(negedge clk);
        test_reset();
        test_fetch();
        test_priority();
        test_mask_store();
        test_starve();
        test_back_to_back();
        test_wait();
        test_reset_wait();
        test_random();
`ifdef KRONOS_MEM_TOHOST_EN
        test_tohost();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
